// File: rtl/time_of_day_counter_if.sv
// Bundle of control, load, setting and display signals for time_of_day_counter.
// Alarm signals are present only when TOD_ALARM_EN is defined.
interface time_of_day_counter_if;
    logic       run;
    logic       load;
    logic [4:0] ld_hour;
    logic [5:0] ld_min;
    logic [5:0] ld_sec;
    logic [1:0] inc_sel;
    logic       mode12;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [4:0] hour_disp;
    logic       pm;
    logic       sec_tick;
    logic       day_wrap;
`ifdef TOD_ALARM_EN
    logic       al_en;
    logic [4:0] al_hour;
    logic [5:0] al_min;
    logic       alarm;

    modport master (
        output run, load, ld_hour, ld_min, ld_sec, inc_sel, mode12, al_en, al_hour, al_min,
        input  sec, min, hour, hour_disp, pm, sec_tick, day_wrap, alarm
    );
    modport slave (
        input  run, load, ld_hour, ld_min, ld_sec, inc_sel, mode12, al_en, al_hour, al_min,
        output sec, min, hour, hour_disp, pm, sec_tick, day_wrap, alarm
    );
`else
    modport master (
        output run, load, ld_hour, ld_min, ld_sec, inc_sel, mode12,
        input  sec, min, hour, hour_disp, pm, sec_tick, day_wrap
    );
    modport slave (
        input  run, load, ld_hour, ld_min, ld_sec, inc_sel, mode12,
        output sec, min, hour, hour_disp, pm, sec_tick, day_wrap
    );
`endif
endinterface

// File: rtl/time_of_day_counter.sv
// Time-of-day counter: prescaler plus a single sec/min/hour carry chain with load,
// per-field setting and 12/24-hour display. Optional alarm compare under TOD_ALARM_EN.
module time_of_day_counter #(
    parameter int TICK_DIV = 50000000
) (
    input  logic                  clk,
    input  logic                  rst,
    time_of_day_counter_if.slave  bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    function automatic logic [5:0] sat59(input logic [5:0] v);
        return (v > 6'd59) ? 6'd59 : v;
    endfunction

    function automatic logic [4:0] sat23(input logic [4:0] v);
        return (v > 5'd23) ? 5'd23 : v;
    endfunction

    logic [PW-1:0] presc_r, presc_s;
    logic [5:0]    sec_r, sec_s, min_r, min_s;
    logic [4:0]    hour_r, hour_s;
    logic          sec_tick_r, sec_tick_s, day_wrap_r, day_wrap_s;
    logic          adv_s;
    logic [4:0]    hour_mod_s, hour_disp_s;
    logic          alarm_r, alarm_s;

    // Next-state: load beats field increment beats prescaler advance
    always_comb begin
        presc_s    = presc_r;
        sec_s      = sec_r;
        min_s      = min_r;
        hour_s     = hour_r;
        sec_tick_s = 1'b0;
        day_wrap_s = 1'b0;
        alarm_s    = 1'b0;
        adv_s      = bus.run && (presc_r == PRESC_LAST);
        if (bus.load) begin
            presc_s = '0;
            sec_s   = sat59(bus.ld_sec);
            min_s   = sat59(bus.ld_min);
            hour_s  = sat23(bus.ld_hour);
        end else begin
            if (bus.run) begin
                presc_s = adv_s ? '0 : presc_r + PW'(1);
            end else begin
                presc_s = presc_r;
            end
            // A coinciding advance is swallowed by any increment
            case (bus.inc_sel)
                2'b01:   sec_s  = (sec_r  == 6'd59) ? 6'd0 : sec_r  + 6'd1;
                2'b10:   min_s  = (min_r  == 6'd59) ? 6'd0 : min_r  + 6'd1;
                2'b11:   hour_s = (hour_r == 5'd23) ? 5'd0 : hour_r + 5'd1;
                default: begin
                    if (adv_s) begin
                        sec_tick_s = 1'b1;
                        if (sec_r == 6'd59) begin
                            sec_s = 6'd0;
                            if (min_r == 6'd59) begin
                                min_s = 6'd0;
                                if (hour_r == 5'd23) begin
                                    hour_s     = 5'd0;
                                    day_wrap_s = 1'b1;
                                end else begin
                                    hour_s = hour_r + 5'd1;
                                end
                            end else begin
                                min_s = min_r + 6'd1;
                            end
                        end else begin
                            sec_s = sec_r + 6'd1;
                        end
`ifdef TOD_ALARM_EN
                        alarm_s = bus.al_en && (sec_s == 6'd0) && (min_s == bus.al_min)
                                  && (hour_s == bus.al_hour);
`endif
                    end else begin
                        sec_tick_s = 1'b0;
                    end
                end
            endcase
        end
    end

    // State and pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r    <= '0;
            sec_r      <= 6'd0;
            min_r      <= 6'd0;
            hour_r     <= 5'd0;
            sec_tick_r <= 1'b0;
            day_wrap_r <= 1'b0;
            alarm_r    <= 1'b0;
        end else begin
            presc_r    <= presc_s;
            sec_r      <= sec_s;
            min_r      <= min_s;
            hour_r     <= hour_s;
            sec_tick_r <= sec_tick_s;
            day_wrap_r <= day_wrap_s;
            alarm_r    <= alarm_s;
        end
    end

    // Display mapping: midnight and noon show as 12 in 12-hour mode
    always_comb begin
        hour_mod_s = (hour_r >= 5'd12) ? hour_r - 5'd12 : hour_r;
        if (bus.mode12) begin
            hour_disp_s = (hour_mod_s == 5'd0) ? 5'd12 : hour_mod_s;
        end else begin
            hour_disp_s = hour_r;
        end
    end

    assign bus.sec       = sec_r;
    assign bus.min       = min_r;
    assign bus.hour      = hour_r;
    assign bus.hour_disp = hour_disp_s;
    assign bus.pm        = (hour_r >= 5'd12);
    assign bus.sec_tick  = sec_tick_r;
    assign bus.day_wrap  = day_wrap_r;
`ifdef TOD_ALARM_EN
    assign bus.alarm     = alarm_r;
`else
    logic unused_alarm_s;
    assign unused_alarm_s = alarm_r;
`endif
endmodule

// File: tb/tb_time_of_day_counter.sv
// Randomized self-checking bench for time_of_day_counter against a seconds-of-day model.
// Alarm checks are compiled in when TOD_ALARM_EN is defined.
module tb_time_of_day_counter;
    localparam int TD = 4;
    localparam int DAY = 86400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    time_of_day_counter_if bus ();
    time_of_day_counter_if bus1 ();

    time_of_day_counter #(.TICK_DIV(TD)) dut (.clk(clk), .rst(rst), .bus(bus));
    time_of_day_counter #(.TICK_DIV(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_checks = 0;
    int n_errors = 0;

    // Reference: time kept as seconds since midnight plus a cycle counter
    int   m_t, m_pc;
    logic m_tick, m_wrap, m_alarm;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    task automatic model_step();
        int h, mi, s;
        logic adv;
        if (rst) begin
            m_t = 0; m_pc = 0; m_tick = 1'b0; m_wrap = 1'b0; m_alarm = 1'b0;
        end else begin
            adv = bus.run && (m_pc == TD - 1);
            m_tick = 1'b0; m_wrap = 1'b0; m_alarm = 1'b0;
            if (bus.load) m_pc = 0;
            else if (bus.run) m_pc = (m_pc + 1) % TD;
            h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
            if (bus.load) begin
                m_t = sat(int'(bus.ld_hour), 23) * 3600 + sat(int'(bus.ld_min), 59) * 60
                      + sat(int'(bus.ld_sec), 59);
            end else if (bus.inc_sel != 2'd0) begin
                if (bus.inc_sel == 2'd1) s = (s + 1) % 60;
                else if (bus.inc_sel == 2'd2) mi = (mi + 1) % 60;
                else h = (h + 1) % 24;
                m_t = h * 3600 + mi * 60 + s;
            end else if (adv) begin
                m_t = (m_t + 1) % DAY;
                m_tick = 1'b1;
                m_wrap = (m_t == 0);
`ifdef TOD_ALARM_EN
                m_alarm = bus.al_en && (m_t == int'(bus.al_hour) * 3600 + int'(bus.al_min) * 60);
`endif
            end
        end
    endtask

    task automatic check_all();
        int h, hd;
        h  = m_t / 3600;
        hd = bus.mode12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
        check_val("sec",  32'(bus.sec),  m_t % 60);
        check_val("min",  32'(bus.min),  (m_t / 60) % 60);
        check_val("hour", 32'(bus.hour), h);
        check_val("hour_disp", 32'(bus.hour_disp), hd);
        check_val("pm", 32'(bus.pm), (h >= 12) ? 1 : 0);
        check_val("sec_tick", 32'(bus.sec_tick), 32'(m_tick));
        check_val("day_wrap", 32'(bus.day_wrap), 32'(m_wrap));
`ifdef TOD_ALARM_EN
        check_val("alarm", 32'(bus.alarm), 32'(m_alarm));
`endif
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_load(input int h, input int mi, input int s);
        bus.load = 1'b1;
        bus.ld_hour = 5'(h); bus.ld_min = 6'(mi); bus.ld_sec = 6'(s);
        step();
        bus.load = 1'b0;
    endtask

    initial begin
        int cnt;
        bus.run = 1'b0; bus.load = 1'b0; bus.ld_hour = 5'd0; bus.ld_min = 6'd0;
        bus.ld_sec = 6'd0; bus.inc_sel = 2'd0; bus.mode12 = 1'b1;
        bus1.run = 1'b1; bus1.load = 1'b0; bus1.ld_hour = 5'd0; bus1.ld_min = 6'd0;
        bus1.ld_sec = 6'd0; bus1.inc_sel = 2'd0; bus1.mode12 = 1'b0;
`ifdef TOD_ALARM_EN
        bus.al_en = 1'b0; bus.al_hour = 5'd0; bus.al_min = 6'd0;
        bus1.al_en = 1'b0; bus1.al_hour = 5'd0; bus1.al_min = 6'd0;
`endif
        m_t = 0; m_pc = 0; m_tick = 1'b0; m_wrap = 1'b0; m_alarm = 1'b0;

        // Reset state
        rst = 1'b1;
        step(); step();
        check_val("rst_hour_disp12", 32'(bus.hour_disp), 12);
        check_val("rst_sec_tick", 32'(bus.sec_tick), 0);
        rst = 1'b0;
        bus.run = 1'b1;

        // Count from reset; TICK_DIV=1 instance ticks every cycle
        cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (bus.sec_tick) cnt++;
            if (k <= 5) begin
                check_val("div1_tick", 32'(bus1.sec_tick), 1);
                check_val("div1_sec", 32'(bus1.sec), k);
            end
        end
        check_val("ticks_in_12", cnt, 3);
        check_val("sec_after_3", 32'(bus.sec), 3);

        // Full day rollover
        do_load(23, 59, 58);
        cnt = 0;
        repeat (8) begin
            step();
            if (bus.day_wrap) cnt++;
        end
        check_val("wrap_count", cnt, 1);
        check_val("wrap_tick", 32'(bus.sec_tick), 1);
        check_val("wrap_hour", 32'(bus.hour), 0);
        check_val("wrap_pm", 32'(bus.pm), 0);

        // Saturating load and prescaler clear
        do_load(31, 63, 60);
        check_val("sat_hour", 32'(bus.hour), 23);
        check_val("sat_min", 32'(bus.min), 59);
        check_val("sat_sec", 32'(bus.sec), 59);
        cnt = 0;
        while (!bus.sec_tick && cnt < 20) begin
            step();
            cnt++;
        end
        check_val("load_to_tick", cnt, TD);

        // Increments never carry
        do_load(10, 59, 30);
        bus.inc_sel = 2'b10; step(); bus.inc_sel = 2'b00;
        check_val("inc_min_wrap", 32'(bus.min), 0);
        check_val("inc_min_hour", 32'(bus.hour), 10);
        do_load(23, 15, 0);
        bus.inc_sel = 2'b11; step(); bus.inc_sel = 2'b00;
        check_val("inc_hour_wrap", 32'(bus.hour), 0);
        do_load(5, 5, 5);
        repeat (3) step();
        bus.inc_sel = 2'b01; step(); bus.inc_sel = 2'b00;
        check_val("inc_adv_tick", 32'(bus.sec_tick), 0);
        check_val("inc_adv_sec", 32'(bus.sec), 6);

        // Pause keeps prescaler position
        do_load(1, 2, 3);
        repeat (2) step();
        bus.run = 1'b0;
        repeat (10) step();
        check_val("pause_sec", 32'(bus.sec), 3);
        bus.run = 1'b1;
        step(); step();
        check_val("resume_tick", 32'(bus.sec_tick), 1);

        // Reset wins over load
        rst = 1'b1; bus.load = 1'b1;
        bus.ld_hour = 5'd12; bus.ld_min = 6'd30; bus.ld_sec = 6'd30;
        step();
        rst = 1'b0; bus.load = 1'b0;
        check_val("rst_load_hour", 32'(bus.hour), 0);
        check_val("rst_load_min", 32'(bus.min), 0);

`ifdef TOD_ALARM_EN
        bus.al_hour = 5'd7; bus.al_min = 6'd30; bus.al_en = 1'b1;
        do_load(7, 29, 59);
        cnt = 0;
        repeat (TD) begin step(); if (bus.alarm) cnt++; end
        check_val("alarm_hit", cnt, 1);
        do_load(7, 30, 0);
        cnt = 32'(bus.alarm);
        repeat (TD) begin step(); if (bus.alarm) cnt++; end
        check_val("alarm_on_load", cnt, 0);
        bus.al_en = 1'b0;
        do_load(7, 29, 59);
        cnt = 0;
        repeat (TD) begin step(); if (bus.alarm) cnt++; end
        check_val("alarm_disabled", cnt, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom % 100) == 0;
            bus.load = ($urandom % 20) == 0;
            if ($urandom % 2 == 0) begin
                bus.ld_hour = 5'd23; bus.ld_min = 6'd59; bus.ld_sec = 6'(56 + $urandom % 4);
            end else begin
                bus.ld_hour = 5'($urandom); bus.ld_min = 6'($urandom); bus.ld_sec = 6'($urandom);
            end
            bus.inc_sel = (($urandom % 8) == 0) ? 2'($urandom) : 2'd0;
            bus.run = ($urandom % 10) != 0;
            if (($urandom % 50) == 0) bus.mode12 = ~bus.mode12;
`ifdef TOD_ALARM_EN
            bus.al_en = 1'($urandom);
            bus.al_hour = 5'(($urandom % 2 == 0) ? 0 : 23);
            bus.al_min = 6'(($urandom % 2 == 0) ? 0 : 59);
`endif
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/time_of_day_counter.md
# time_of_day_counter

Parametrised time-of-day counter generating seconds, minutes and hours from the system clock through an internal prescaler, with synchronous load, per-field increment for user setting, 12/24-hour display mapping and day-rollover indication. It sits between the clock source and the display/decoder logic of the digital clock. It replaces the separate cascaded second/minute/hour converters with one carry chain, so cross-module resynchronisation offsets are not needed.

## Interface
- TICK_DIV, 50000000, clk cycles per second; legal range >= 1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- run  in  1  1 = prescaler counts and time advances; 0 = prescaler and time frozen
- load  in  1  one-cycle strobe: load ld_hour/ld_min/ld_sec
- ld_hour  in  5  load value, hours 0-23
- ld_min  in  6  load value, minutes 0-59
- ld_sec  in  6  load value, seconds 0-59
- inc_sel  in  2  field increment: 00 none, 01 sec, 10 min, 11 hour; acts on every cycle it is nonzero
- mode12  in  1  1 = 12-hour display mapping on hour_disp/pm
- sec  out  6  seconds 0-59
- min  out  6  minutes 0-59
- hour  out  5  hours 0-23, always 24-hour internal
- hour_disp  out  5  mode12=0: equals hour; mode12=1: 12 for hour 0/12, else hour mod 12
- pm  out  1  1 when hour >= 12, independent of mode12
- sec_tick  out  1  one-cycle pulse on each prescaler-driven second advance
- day_wrap  out  1  one-cycle pulse on 23:59:59 -> 00:00:00 advance
- al_en, al_hour(5), al_min(6)  in  alarm enable and time (present only with TOD_ALARM_EN)
- alarm  out  1  alarm pulse (present only with TOD_ALARM_EN)

## Operation
- Prescaler: width max(1, clog2(TICK_DIV)); counts 0..TICK_DIV-1 while run=1; holds while run=0. At TICK_DIV-1 with run=1: wraps to 0 and issues an advance.
- Advance: sec+1; at 59 sec->0 with min carry; min 59->0 with hour carry; hour 23->0 with day_wrap.
- Priority per cycle: rst > load > inc_sel > advance.
- rst: sec=min=hour=0, prescaler=0, sec_tick=day_wrap=alarm=0. Consequently hour_disp=12 if mode12, else 0; pm=0.
- load: fields loaded; out-of-range values saturate (sec/min >59 -> 59, hour >23 -> 23). Prescaler cleared to 0. No pulses are asserted.
- inc_sel: selected field +1, wrapping within its own range (59->0, 23->0). Never carries into the next field. Prescaler continues counting. An advance coinciding with an increment is dropped, and sec_tick stays 0.
- hour_disp and pm are combinational from registered hour and mode12. All other outputs are registered.

## Timing
- Advance occurs on the edge where the prescaler is at TICK_DIV-1 and run=1. New sec/min/hour are visible after that edge, with sec_tick (and day_wrap if applicable) high for exactly that following cycle.
- From reset release with run=1, the first sec_tick occurs TICK_DIV cycles later. For TICK_DIV=1, sec_tick is high every cycle.
- load and inc take effect one edge after being sampled high.
- run deasserted mid-count: the prescaler value is retained; counting resumes from the same value.
- rst asserted mid-operation overrides everything on that edge; there are no partial updates.

## Configuration
- TOD_ALARM_EN defined: adds al_en, al_hour, al_min, alarm. alarm pulses one cycle, coincident with sec_tick, when an advance produces hour==al_hour, min==al_min, sec==0 and al_en=1. Loads and increments never trigger alarm. Reset value of alarm is 0.
- TOD_ALARM_EN undefined: these ports and their logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset/count, TICK_DIV=4: rst then run=1 -> sec_tick every 4th cycle; after 3 ticks sec=3, min=0, hour=0; hour_disp=12 with mode12=1.
- Full rollover: load 23:59:58, run -> 23:59:59, then 00:00:00 with day_wrap and sec_tick both high for one cycle, pm 1->0.
- Load saturation and prescaler clear: load 31:63:60 -> 23:59:59; next sec_tick exactly TICK_DIV cycles after load.
- Increment no-carry: at 10:59:30, inc_sel=10 for one cycle -> 10:00:30. At 23:xx, inc_sel=11 -> hour 0. Increment on an advance cycle -> increment applied, advance dropped, sec_tick=0.
- run/rst mid-operation: run=0 for 10 cycles mid-second -> no change, and the remaining prescaler count is preserved. rst asserted together with load -> all zero.
- TOD_ALARM_EN: al 07:30, al_en=1, load 07:29:59 -> alarm pulse with the 07:30:00 sec_tick. Load 07:30:00 directly -> no alarm. al_en=0 -> no alarm.
